result_display: RTL
===================

RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter ACTIVE_LOW, default 1, meaning 1 = segment lit by driving 0 (board default), 0 = all segment bits inverted.
REQ-002 SHALL have parameter BLANK_ZEROS, default 1, meaning 1 = tens digit blanked when zero, 0 = tens zero shown.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  result word present on in_data.
REQ-006 SHALL have port in_data  input  6  adder/subtractor result q5..q0, with q5 as MSB.
REQ-007 SHALL have port in_signed  input  1  1 = in_data is two's complement, 0 = unsigned; sampled with in_data.
REQ-008 SHALL have port in_ready  output  1  block idle and accepting.
REQ-009 SHALL have port hex0  output  8  units digit segments; bit7 = DP, bits6..0 = g..a.
REQ-010 SHALL have port hex1  output  8  tens digit segments.
REQ-011 SHALL have port hex2  output  8  sign position segments.
REQ-012 SHALL have port out_valid  output  1  one-cycle pulse marking that hex0..hex2 have just been updated.

Function
REQ-013 SHALL implement FSM states IDLE, CONV, DONE; in_ready SHALL equal (state==IDLE).
REQ-014 SHALL accept on a rising edge with in_valid=1 and in_ready=1, capture sign and magnitude, load counter=0 and BCD=0, and go to CONV.
REQ-015 SHALL derive the captured magnitude as follows: in_signed=1 with in_data[5]=1 gives neg=1 and magnitude = (-in_data) as a 6-bit unsigned value, so -32 maps to 32; otherwise neg=0 and magnitude = in_data.
REQ-016 SHALL, in each CONV cycle, add 3 to every BCD nibble >=5, then shift {BCD, magnitude} left by 1, then increment the counter.
REQ-017 SHALL move from CONV to DONE on the edge that performs the 6th shift, and from DONE to IDLE on the next edge.
REQ-018 SHALL load hex0..hex2 on the DONE->IDLE edge and assert out_valid for exactly the following cycle; accept-to-update latency is 7 clocks.
REQ-019 SHALL drive hex0 to the units digit encoding, always shown.
REQ-020 SHALL drive hex1 to the tens digit encoding; with BLANK_ZEROS=1 and tens==0, hex1 SHALL be blank.
REQ-021 SHALL drive hex2 to '-' (0xBF active-low) when neg=1 and to blank otherwise.
REQ-022 SHALL use these active-low digit encodings: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
REQ-023 SHALL encode blank as 0xFF and keep the DP bit unlit in all cases; with ACTIVE_LOW=0 every output byte SHALL be the bitwise inverse.
REQ-024 SHALL ignore in_valid while in_ready=0, with no queuing, and SHALL NOT alter captured data during CONV/DONE.
REQ-025 SHALL hold hex0..hex2 stable between updates, including while a new conversion runs.
REQ-026 SHALL accept a new word in the cycle immediately after out_valid (back-to-back accepts every 8 cycles).
REQ-027 SHALL treat any in_data as legal; the maximum displayed magnitude is 63 unsigned and 32 signed.

Reset
REQ-028 SHALL, when rst=1 on an edge, set state=IDLE, hex0..hex2 = blank, out_valid=0, counter=0 and BCD=0, overriding any accept in that cycle.
REQ-029 SHALL, on rst during CONV or DONE, abort the conversion: no out_valid, displays blank, in_ready=1 on the following cycle.

Verification
REQ-030 SHALL cover reset: hold rst 2 cycles -> hex0/hex1/hex2 = FF, in_ready=1, out_valid=0.
REQ-031 SHALL cover unsigned 63: in_data=6'b111111, in_signed=0 -> 7 clocks later hex2=FF, hex1=82, hex0=B0, out_valid pulse of 1 cycle.
REQ-032 SHALL cover signed negatives: in_data=6'b100000, in_signed=1 -> hex2=BF, hex1=B0, hex0=A4; and in_data=6'b111111, in_signed=1 -> hex2=BF, hex1=FF, hex0=F9.
REQ-033 SHALL cover zero blanking: in_data=5, in_signed=0 -> hex1=FF, hex0=92; with BLANK_ZEROS=0 -> hex1=C0; with ACTIVE_LOW=0 -> hex0=6D.
REQ-034 SHALL cover busy-ignore and back-to-back: accept 12, drive in_valid with 7 during CONV -> display shows 12; then accept 7 on the cycle after out_valid -> display shows 7 seven clocks later.
REQ-035 SHALL cover reset mid-operation: accept 45, assert rst at the 3rd CONV cycle -> no out_valid, hex0..hex2 = FF, in_ready=1 the next cycle.

Source files
------------

// File: rtl/result_display.sv
// result_display
// Converts a 6-bit adder/subtractor result to a three-position seven-segment
// display: sign, tens and units. A binary-to-BCD shift-and-add-3 converter
// runs over six clocks per word. The displays update together, and out_valid
// marks the update.
//
// Parameters:
//   ACTIVE_LOW  - 1: segment lit by driving 0; 0: every output bit inverted
//   BLANK_ZEROS - 1: tens digit blanked when zero; 0: tens zero shown
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   in_valid   - result word present on in_data
//   in_data    - result q5..q0 (q5 = MSB)
//   in_signed  - 1: in_data is two's complement; 0: unsigned
//   in_ready   - block idle and accepting
//   hex0       - units digit segments {DP, g..a}
//   hex1       - tens digit segments
//   hex2       - sign position segments
//   out_valid  - one-cycle pulse after hex0..hex2 update
module result_display #(
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [5:0] in_data,
  input  logic       in_signed,
  output logic       in_ready,
  output logic [7:0] hex0,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic       out_valid
);

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Active-low segment pattern for one decimal digit. The DP bit stays unlit.
  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    case (d)
      4'd0:    digit_seg = 8'hC0;
      4'd1:    digit_seg = 8'hF9;
      4'd2:    digit_seg = 8'hA4;
      4'd3:    digit_seg = 8'hB0;
      4'd4:    digit_seg = 8'h99;
      4'd5:    digit_seg = 8'h92;
      4'd6:    digit_seg = 8'h82;
      4'd7:    digit_seg = 8'hF8;
      4'd8:    digit_seg = 8'h80;
      4'd9:    digit_seg = 8'h90;
      default: digit_seg = SEG_BLANK;
    endcase
  endfunction

  // Apply board polarity to an active-low pattern.
  function automatic logic [7:0] drive_pol(input logic [7:0] seg_al);
    if (ACTIVE_LOW) begin
      drive_pol = seg_al;
    end else begin
      drive_pol = ~seg_al;
    end
  endfunction

  // Add 3 to each BCD nibble that is 5 or more, so the next shift carries correctly.
  function automatic logic [7:0] bcd_adjust(input logic [7:0] b);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = b[3:0];
    hi = b[7:4];
    if (lo >= 4'd5) begin
      lo = lo + 4'd3;
    end else begin
      lo = lo;
    end
    if (hi >= 4'd5) begin
      hi = hi + 4'd3;
    end else begin
      hi = hi;
    end
    bcd_adjust = {hi, lo};
  endfunction

  state_t     state_r;
  logic [2:0] cnt_r;
  logic [7:0] bcd_r;
  logic [5:0] mag_r;
  logic       neg_r;
  logic [7:0] hex0_r;
  logic [7:0] hex1_r;
  logic [7:0] hex2_r;
  logic       out_valid_r;

  logic [7:0] bcd_adj_s;
  logic       in_neg_s;
  logic [5:0] neg_mag_s;
  logic [7:0] units_seg_s;
  logic [7:0] tens_seg_s;
  logic [7:0] sign_seg_s;

  // Capture-side magnitude, BCD adjust, and the segment patterns for the final result.
  always_comb begin
    bcd_adj_s   = bcd_adjust(bcd_r);
    in_neg_s    = in_signed & in_data[5];
    // Negating 6'b100000 wraps back to 32, which is the required -32 magnitude.
    neg_mag_s   = 6'd0 - in_data;
    units_seg_s = digit_seg(bcd_r[3:0]);
    if (BLANK_ZEROS && (bcd_r[7:4] == 4'd0)) begin
      tens_seg_s = SEG_BLANK;
    end else begin
      tens_seg_s = digit_seg(bcd_r[7:4]);
    end
    if (neg_r) begin
      sign_seg_s = SEG_MINUS;
    end else begin
      sign_seg_s = SEG_BLANK;
    end
  end

  // Control FSM, converter datapath and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 3'd0;
      bcd_r       <= 8'd0;
      mag_r       <= 6'd0;
      neg_r       <= 1'b0;
      hex0_r      <= drive_pol(SEG_BLANK);
      hex1_r      <= drive_pol(SEG_BLANK);
      hex2_r      <= drive_pol(SEG_BLANK);
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            neg_r   <= in_neg_s;
            mag_r   <= in_neg_s ? neg_mag_s : in_data;
            cnt_r   <= 3'd0;
            bcd_r   <= 8'd0;
            state_r <= CONV;
          end
        end
        CONV: begin
          {bcd_r, mag_r} <= {bcd_adj_s, mag_r} << 1;
          cnt_r          <= cnt_r + 3'd1;
          // cnt_r == 5 means this edge performs the sixth and final shift.
          if (cnt_r == 3'd5) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          hex0_r      <= drive_pol(units_seg_s);
          hex1_r      <= drive_pol(tens_seg_s);
          hex2_r      <= drive_pol(sign_seg_s);
          out_valid_r <= 1'b1;
          state_r     <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_r == IDLE);
  assign hex0      = hex0_r;
  assign hex1      = hex1_r;
  assign hex2      = hex2_r;
  assign out_valid = out_valid_r;

endmodule
